// File: rtl/f1_race_ctrl.sv
// F1 starting-lights reaction timer: lights sequence, random hold, reaction count, best time.
// Latency: key presses act 3 clk edges after the raw key is first sampled low; outputs are registered.
// No backpressure: inputs are strobes and raw keys, and outputs are level signals that are always valid.
module f1_race_ctrl #(
    parameter int LIGHT_STEP_MS = 500,
    parameter int MIN_DELAY_MS  = 250,
    parameter int MAX_MS        = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1ms,
    input  logic        key_start,
    input  logic        key_react,
    input  logic [11:0] rand_val,
    output logic        lfsr_en,
    output logic [9:0]  lights,
    output logic [13:0] react_ms,
    output logic [13:0] best_ms,
    output logic        result_valid,
    output logic        false_start,
    output logic        busy
);

    // Parameters narrowed once so every counter compare is a plain 14-bit compare.
    localparam logic [13:0] STEP_W = 14'(LIGHT_STEP_MS);
    localparam logic [13:0] MIN_W  = 14'(MIN_DELAY_MS);
    localparam logic [13:0] MAX_W  = 14'(MAX_MS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTS,
        S_HOLD,
        S_GO,
        S_RESULT,
        S_FAULT
    } state_t;

    state_t      state;
    logic [13:0] step_cnt;
    logic [13:0] hold_cnt;

    // Two-flop synchronizers per key, reset to the released (high) level.
    logic        start_s1;
    logic        start_s2;
    logic        react_s1;
    logic        react_s2;

    // Tracks how many real samples have reached the second sync flop since reset.
    // Until it fills, the sync output is only the reset value, not the key.
    logic [1:0]  sync_fill;

    // Set when the last genuine synchronized sample of the key was high.
    // A press needs a real high followed by a real low, so a key held
    // down across reset never produces a press.
    logic        start_hi;
    logic        react_hi;

    logic        start_press;
    logic        react_press;

    // Key synchronization and released-level tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1  <= 1'b1;
            start_s2  <= 1'b1;
            react_s1  <= 1'b1;
            react_s2  <= 1'b1;
            sync_fill <= 2'b00;
            start_hi  <= 1'b0;
            react_hi  <= 1'b0;
        end else begin
            start_s1  <= key_start;
            start_s2  <= start_s1;
            react_s1  <= key_react;
            react_s2  <= react_s1;
            sync_fill <= {sync_fill[0], 1'b1};
            start_hi  <= sync_fill[1] & start_s2;
            react_hi  <= sync_fill[1] & react_s2;
        end
    end

    // A press is the single cycle where a genuine high has just turned low.
    always_comb begin
        start_press = start_hi & ~start_s2;
        react_press = react_hi & ~react_s2;
    end

    // Race sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lights       <= 10'h000;
            lfsr_en      <= 1'b0;
            react_ms     <= 14'd0;
            best_ms      <= MAX_W;
            result_valid <= 1'b0;
            false_start  <= 1'b0;
            busy         <= 1'b0;
            step_cnt     <= 14'd0;
            hold_cnt     <= 14'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The LFSR free-runs while waiting so the hold delay is unpredictable.
                    lfsr_en <= 1'b1;
                    lights  <= 10'h000;
                    if (start_press) begin
                        state    <= S_LIGHTS;
                        busy     <= 1'b1;
                        step_cnt <= 14'd0;
                    end
                end

                S_LIGHTS: begin
                    if (react_press) begin
                        // Jumping the lights is a false start; the shown result is kept.
                        state       <= S_FAULT;
                        lights      <= 10'h3FF;
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                        lfsr_en     <= 1'b1;
                        step_cnt    <= 14'd0;
                    end else if (tick_1ms) begin
                        if (step_cnt + 14'd1 == STEP_W) begin
                            step_cnt <= 14'd0;
                            if (lights == 10'h3FF) begin
                                // All lights lit: freeze the random value into the hold delay.
                                state    <= S_HOLD;
                                hold_cnt <= MIN_W + {2'b00, rand_val};
                                lfsr_en  <= 1'b0;
                            end else begin
                                lights <= {lights[8:0], 1'b1};
                            end
                        end else begin
                            step_cnt <= step_cnt + 14'd1;
                        end
                    end
                end

                S_HOLD: begin
                    if (react_press) begin
                        state       <= S_FAULT;
                        false_start <= 1'b1;
                        busy        <= 1'b0;
                        lfsr_en     <= 1'b1;
                        hold_cnt    <= 14'd0;
                    end else if (tick_1ms) begin
                        // A zero-length hold also exits here rather than wrapping.
                        if (hold_cnt <= 14'd1) begin
                            state    <= S_GO;
                            lights   <= 10'h000;
                            react_ms <= 14'd0;
                            hold_cnt <= 14'd0;
                        end else begin
                            hold_cnt <= hold_cnt - 14'd1;
                        end
                    end
                end

                S_GO: begin
                    if (react_press) begin
                        // The press beats a coincident tick, so the count is not bumped.
                        state        <= S_RESULT;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        lfsr_en      <= 1'b1;
                        if (react_ms < best_ms) begin
                            best_ms <= react_ms;
                        end
                    end else if (tick_1ms) begin
                        if (react_ms + 14'd1 >= MAX_W) begin
                            // Timed out: show the saturated count, leave best untouched.
                            react_ms     <= MAX_W;
                            state        <= S_RESULT;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            lfsr_en      <= 1'b1;
                        end else begin
                            react_ms <= react_ms + 14'd1;
                        end
                    end
                end

                S_RESULT, S_FAULT: begin
                    // Start restarts the round directly and outranks a coincident react.
                    if (start_press) begin
                        state        <= S_LIGHTS;
                        lights       <= 10'h000;
                        step_cnt     <= 14'd0;
                        result_valid <= 1'b0;
                        false_start  <= 1'b0;
                        busy         <= 1'b1;
                        lfsr_en      <= 1'b1;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    lights       <= 10'h000;
                    result_valid <= 1'b0;
                    false_start  <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
